// File: rtl/sqrt_pkg.sv
// Shared types and constants for the sqrt command sequencer.
//   Command_s : one FIFO entry {header, value}
//   CMD_STOP / CMD_SQRT : header encodings
//   state_e   : sequencer FSM states
package sqrt_pkg;

  localparam logic CMD_STOP = 1'b0;
  localparam logic CMD_SQRT = 1'b1;

  typedef struct packed {
    logic        header;
    logic [15:0] value;
  } Command_s;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT,
    ST_HALT
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO for the sqrt sequencer.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, din_i     : write din_i at the tail (ignored when full)
//   pop_i, dout_o     : dout_o is the current head; pop_i removes it (ignored when empty)
//   full_o, empty_o   : occupancy flags
// The head is read straight from storage, so an entry written in one cycle is
// visible at the head only from the following cycle (no bypass path).
module cmd_fifo
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  Command_s din_i,
  input  logic     pop_i,
  output Command_s dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  Command_s      mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sqrt_cmd_sequencer.sv
// Sequences queued sqrt commands onto an external sqrt stage and reports
// one result record per compute command, in command order.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o       : command handshake; cmd_header_i (1=sqrt, 0=stop),
//                                   cmd_value_i (radicand)
//   valor_o, start_o              : radicand and run pin toward the sqrt stage
//   endop_i, sqrt_i               : sqrt stage done flag and root
//   res_valid_o/res_ready_i       : result handshake; res_value_o, res_root_o,
//                                   res_timeout_o form the record
//   busy_o, stopped_o             : status (operation in flight / halted)
module sqrt_cmd_sequencer
  import sqrt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_header_i,
  input  logic [15:0] cmd_value_i,
  output logic [15:0] valor_o,
  output logic        start_o,
  input  logic        endop_i,
  input  logic [7:0]  sqrt_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_value_o,
  output logic [7:0]  res_root_o,
  output logic        res_timeout_o,
  output logic        busy_o,
  output logic        stopped_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [15:0] valor_q, valor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  root_q, root_d;
  logic        tmo_q, tmo_d;
  // Holds cmd_ready low while in reset and until the first edge after release.
  logic        ready_en_q;

  Command_s    fifo_head;
  Command_s    fifo_din;
  logic        fifo_full, fifo_empty;
  logic        fifo_push, fifo_pop;

  assign fifo_din.header = cmd_header_i;
  assign fifo_din.value  = cmd_value_i;
  assign stopped_o       = (state_q == ST_HALT);
  assign cmd_ready_o     = ready_en_q && !fifo_full && !stopped_o;
  assign fifo_push       = cmd_valid_i && cmd_ready_o;
  assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign valor_o         = valor_q;
  assign res_value_o     = valor_q;
  assign res_root_o      = root_q;
  assign res_timeout_o   = tmo_q;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    valor_d     = valor_q;
    cnt_d       = cnt_q;
    root_d      = root_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;
    start_o     = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_head.header == CMD_SQRT) begin
            valor_d = fifo_head.value;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_HALT;
          end
        end
      end
      ST_ISSUE: begin
        // endop is not looked at here: the stage may still show the
        // previous operation's flag for this cycle.
        start_o = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        start_o = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (endop_i) begin
          root_d  = sqrt_i;
          tmo_d   = 1'b0;
          state_d = ST_EMIT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          root_d  = '0;
          tmo_d   = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      valor_q    <= '0;
      cnt_q      <= '0;
      root_q     <= '0;
      tmo_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valor_q    <= valor_d;
      cnt_q      <= cnt_d;
      root_q     <= root_d;
      tmo_q      <= tmo_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sqrt_cmd_sequencer.sv
module tb_sqrt_cmd_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_header_i;
  logic [15:0] cmd_value_i;
  logic [15:0] valor_o;
  logic        start_o;
  logic        endop_i;
  logic [7:0]  sqrt_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_value_o;
  logic [7:0]  res_root_o;
  logic        res_timeout_o;
  logic        busy_o;
  logic        stopped_o;

  sqrt_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_header_i(cmd_header_i), .cmd_value_i(cmd_value_i),
    .valor_o(valor_o), .start_o(start_o),
    .endop_i(endop_i), .sqrt_i(sqrt_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_value_o(res_value_o), .res_root_o(res_root_o),
    .res_timeout_o(res_timeout_o),
    .busy_o(busy_o), .stopped_o(stopped_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] v;
    logic [7:0]  r;
    logic        t;
  } rec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q[$];
  logic model_stop = 1'b0;
  int   endop_delay = 0;  // WAIT cycle on which the stage raises endop; 0 = never
  int   hi_cnt = 0;       // cycles start has been high in the current operation
  int   last_hi = 0;      // length of the last completed start-high run

  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int r = 0;
    for (int k = 0; k < 256; k++) if (k * k <= int'(v)) r = k;
    return 8'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Accepted command -> expected record, from the command semantics only.
  function automatic void model_accept(input logic h, input logic [15:0] v);
    rec_t r;
    if (h == 1'b0) model_stop = 1'b1;
    else if (!model_stop) begin
      r.v = v;
      r.t = (endop_delay == 0) || (endop_delay > TIMEOUT);
      r.r = r.t ? 8'd0 : isqrt(v);
      exp_q.push_back(r);
    end
  endfunction

  // Behavioural sqrt stage: first start-high cycle is ISSUE, then WAIT 1, 2, ...
  always @(posedge clk_i) begin
    #1;
    if (start_o) hi_cnt++;
    else begin
      if (hi_cnt > 0) last_hi = hi_cnt;
      hi_cnt = 0;
    end
    endop_i = start_o && (endop_delay != 0) && (hi_cnt == endop_delay + 1);
    sqrt_i  = endop_i ? isqrt(valor_o) : 8'hA5;
  end

  // Compare process: record order/content, hold stability, start low in EMIT.
  logic        hold_pend = 1'b0;
  logic [15:0] hold_v;
  logic [7:0]  hold_r;
  logic        hold_t;
  always @(negedge clk_i) begin
    rec_t e;
    if (!rst_ni) hold_pend = 1'b0;
    else begin
      if (hold_pend) begin
        check("hold_valid", res_valid_o, 1);
        check("hold_value", res_value_o, hold_v);
        check("hold_root", res_root_o, hold_r);
        check("hold_tmo", res_timeout_o, hold_t);
      end
      if (res_valid_o) check("start_low_in_emit", start_o, 0);
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_record", 1, 0);
        else begin
          e = exp_q.pop_front();
          $display("record value=%0d root=%0d timeout=%0d", res_value_o, res_root_o, res_timeout_o);
          check("rec_value", res_value_o, e.v);
          check("rec_root", res_root_o, e.r);
          check("rec_timeout", res_timeout_o, e.t);
        end
      end
      hold_pend = res_valid_o && !res_ready_i;
      hold_v = res_value_o; hold_r = res_root_o; hold_t = res_timeout_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic push(input logic h, input logic [15:0] v);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_header_i = h; cmd_value_i = v;
    while (!cmd_ready_o && n < 2000) begin tick(1); n++; end
    if (!cmd_ready_o) check("push_accept_timeout", 0, 1);
    else begin
      model_accept(h, v);
      tick(1);
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin tick(1); n++; end
    check("drained", exp_q.size(), 0);
    tick(2);
  endtask

  initial begin
    int lat;
    rst_ni = 1'b0; cmd_valid_i = 0; cmd_header_i = 0; cmd_value_i = 0;
    res_ready_i = 0; endop_i = 0; sqrt_i = 0;

    // Model pins
    check("pin_isqrt4", isqrt(16'd4), 2);
    check("pin_isqrt65535", isqrt(16'd65535), 255);
    check("pin_isqrt144", isqrt(16'd144), 12);
    check("pin_isqrt9", isqrt(16'd9), 3);

    // Reset state
    tick(3);
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_valor", valor_o, 0);
    check("rst_start", start_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_value", res_value_o, 0);
    check("rst_res_root", res_root_o, 0);
    check("rst_res_timeout", res_timeout_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_stopped", stopped_o, 0);
    rst_ni = 1'b1;
    tick(1);
    check("ready_after_release", cmd_ready_o, 1);

    // {1,4}, endop on 8th WAIT cycle
    endop_delay = 8; res_ready_i = 1;
    push(1'b1, 16'd4);
    drain();
    check("wait_len_8", last_hi, 9);

    // Minimum latency: endop on first WAIT
    endop_delay = 1;
    push(1'b1, 16'd25);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 0) begin
        @(negedge clk_i);
        if (res_valid_o) lat = i;
        @(posedge clk_i); #1;
      end
    end
    check("min_latency_edges", lat, 4);
    drain();

    // Back-to-back with extreme radicands
    endop_delay = 3;
    push(1'b1, 16'd65535);
    push(1'b1, 16'd0);
    push(1'b1, 16'd144);
    drain();

    // Timeout: endop never asserted
    endop_delay = 0;
    push(1'b1, 16'd100);
    drain();
    check("timeout_wait_len", last_hi, TIMEOUT + 1);

    // endop on the last count wins; one past it times out
    endop_delay = TIMEOUT;
    push(1'b1, 16'd49);
    drain();
    endop_delay = TIMEOUT + 1;
    push(1'b1, 16'd81);
    drain();

    // FIFO full with consumer stalled
    endop_delay = 0; res_ready_i = 0;
    push(1'b1, 16'd1000);
    tick(3);
    check("blocker_busy", busy_o, 1);
    push(1'b1, 16'd1); push(1'b1, 16'd2); push(1'b1, 16'd3); push(1'b1, 16'd4);
    check("full_ready_low", cmd_ready_o, 0);
    cmd_valid_i = 1; cmd_header_i = 1; cmd_value_i = 16'd5;
    tick(10);
    check("fifth_not_accepted", cmd_ready_o, 0);
    res_ready_i = 1;
    begin
      int n = 0;
      while (!cmd_ready_o && n < 500) begin tick(1); n++; end
      check("fifth_accepted_after_pop", cmd_ready_o, 1);
      if (cmd_ready_o) begin model_accept(1'b1, 16'd5); tick(1); end
      cmd_valid_i = 0;
    end
    drain();

    // Stop command halts the sequencer
    endop_delay = 2;
    push(1'b1, 16'd9);
    push(1'b0, 16'd0);
    push(1'b1, 16'd16);
    drain();
    tick(20);
    check("halt_stopped", stopped_o, 1);
    check("halt_cmd_ready", cmd_ready_o, 0);
    check("halt_start", start_o, 0);
    check("halt_busy", busy_o, 0);

    // Reset in the 3rd WAIT cycle
    rst_ni = 0; tick(2); rst_ni = 1; tick(2);
    exp_q.delete(); model_stop = 0;
    endop_delay = 0;
    push(1'b1, 16'd50);
    push(1'b1, 16'd51);
    begin
      int n = 0;
      while (!start_o && n < 20) begin tick(1); n++; end
      check("saw_issue", start_o, 1);
    end
    tick(3);  // now in WAIT cycle 3
    rst_ni = 0;
    #1;
    check("rst_mid_start", start_o, 0);
    check("rst_mid_res_valid", res_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    exp_q.delete(); model_stop = 0;
    tick(2);
    rst_ni = 1;
    tick(1);
    check("rst_mid_ready_after", cmd_ready_o, 1);
    check("rst_mid_stopped", stopped_o, 0);
    tick(80);
    check("fifo_empty_after_reset", busy_o, 0);
    check("no_record_after_reset", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
